hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It watches the instructions held in the FD and DX latches and drives hold, bubble and flush controls to the PC register and the FD, DX and XM latches. It detects load-use hazards and squashes wrong-path instructions on a taken branch. A small FSM sequences the multi-cycle multiply/divide unit by freezing the front end until the unit reports done.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle performance counter

Ports:
- clock  in  1  pipeline clock; state updates on negedge, the same edge as the pipeline latches
- reset  in  1  reset, asynchronous, active-high
- fd_insn  in  32  instruction in the FD latch (decode stage)
- dx_insn  in  32  instruction in the DX latch (execute stage)
- branch_taken  in  1  X-stage branch/jump resolved taken
- md_ready  in  1  mult/div unit result valid
- md_start  out  1  one-cycle start pulse to the mult/div unit
- pc_hold  out  1  PC register keeps its value
- fd_hold  out  1  FD latch keeps its value
- fd_flush  out  1  FD latch loads NOP (32'h00000013)
- dx_hold  out  1  DX latch keeps its value
- dx_bubble  out  1  DX latch loads NOP
- xm_bubble  out  1  XM latch loads NOP
- stall_cnt  out  CNT_W  saturating count of front-end stall cycles

## Operation
- Field decode:
  - opcode = [6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
  - Load is opcode 7'b0000011.
  - M-ext op is opcode 7'b0110011 with funct7 7'b0000001.
- Register use in the FD instruction:
  - rs1 is used for every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 is used only for R (0110011), S (0100011) and B (1100011).
- Load-use condition: DX holds a load, DX rd != 0, and DX rd equals a used rs1 or rs2 of the FD instruction.
  - Response: pc_hold=1, fd_hold=1, dx_bubble=1.
- FSM states: IDLE, MD_BUSY, MD_DONE.
  - IDLE with an M-ext op in DX: md_start=1 combinationally. On the next edge, go to MD_BUSY.
  - MD_BUSY: pc_hold=fd_hold=dx_hold=1 and xm_bubble=1. md_ready=1 moves the FSM to MD_DONE on the edge; otherwise it stays.
  - MD_DONE: no holds, xm_bubble=0, so the result enters XM on this edge. The next state is always IDLE.
  - Starts only from IDLE. The DX instruction advances on the MD_DONE edge, so the same op never restarts.
- Priority, highest first:
  1. MD_BUSY: all other causes are ignored, including branch_taken and load-use.
  2. branch_taken: fd_flush=1 and dx_bubble=1, pc_hold=0, load-use is suppressed.
  3. M-ext start in IDLE.
  4. Load-use.
- Hold and flush of the same latch never assert together.
- md_ready outside MD_BUSY is ignored.
- stall_cnt increments by 1 on each edge where pc_hold=1, and saturates at all-ones.

## Timing
- All outputs except stall_cnt are combinational from the inputs and the FSM state. Zero-cycle latency.
- State and stall_cnt are registered on negedge clock.
- Reset values: FSM=IDLE, stall_cnt=0.
  - With fd_insn=dx_insn=0 and branch_taken=0, every control output is 0.
- Reset asserted mid-MD_BUSY: the FSM goes to IDLE immediately and the holds drop in the same cycle.
  - The mult/div unit is reset by the same signal.
- Minimum MD occupancy is 3 cycles: IDLE(start), MD_BUSY, MD_DONE. This holds even if md_ready is already high in the first BUSY cycle.
- Load-use costs exactly 1 bubble. A taken branch costs 2 bubbles.

## Configuration
- HAZARD_PERF_CNT_EN defined: the stall_cnt register and its increment logic are built as described above.
- Not defined: stall_cnt is tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- Load-use:
  - Stimulus: DX=lw x5,0(x1); FD=add x6,x5,x2.
  - Required: pc_hold=fd_hold=dx_bubble=1 for exactly one cycle. After that edge, DX=NOP and FD is unchanged.
- x0 and unused-rs2 exemption:
  - Stimulus: DX=lw x0,0(x1) with FD=add x6,x0,x0. Then DX=lw x5 with FD=addi x6,x7,5 (imm bits [24:20]=5).
  - Required: all controls 0 in both cases.
- Branch over load-use:
  - Stimulus: branch_taken=1 while a load-use condition is also present.
  - Required: fd_flush=dx_bubble=1, pc_hold=0, fd_hold=0.
- Mult/div sequence:
  - Stimulus: DX=mul x3,x1,x2; md_ready asserted 3 cycles after md_start.
  - Required: md_start is high for exactly 1 cycle. Holds and xm_bubble are high for 4 cycles. MD_DONE lasts 1 cycle, then IDLE, with no second md_start.
- Reset mid-BUSY:
  - Stimulus: assert reset asynchronously 2 cycles into MD_BUSY.
  - Required: outputs return to 0 without waiting for a clock edge. FSM=IDLE, stall_cnt=0.
- Counter saturation:
  - Build with HAZARD_PERF_CNT_EN and CNT_W=4. Hold MD_BUSY for 20 cycles.
  - Required: stall_cnt stops at 15.
  - Build without the macro: stall_cnt stays 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: latch contents, branch/mult-div status in,
// hold/bubble/flush controls and the stall counter out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      fd_insn;
  logic [31:0]      dx_insn;
  logic             branch_taken;
  logic             md_ready;
  logic             md_start;
  logic             pc_hold;
  logic             fd_hold;
  logic             fd_flush;
  logic             dx_hold;
  logic             dx_bubble;
  logic             xm_bubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output fd_insn, dx_insn, branch_taken, md_ready,
    input  md_start, pc_hold, fd_hold, fd_flush, dx_hold, dx_bubble, xm_bubble, stall_cnt
  );

  modport slave (
    input  fd_insn, dx_insn, branch_taken, md_ready,
    output md_start, pc_hold, fd_hold, fd_flush, dx_hold, dx_bubble, xm_bubble, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / taken-branch hazard control and mult/div sequencing for the 5-stage core.
// HAZARD_PERF_CNT_EN builds the saturating stall-cycle counter; otherwise stall_cnt is 0.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input logic         clock,
  input logic         reset,
  hazard_ctrl_if.slave bus
);
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpS     = 7'b0100011;
  localparam logic [6:0] OpB     = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;

  typedef enum logic [1:0] {StIdle, StMdBusy, StMdDone} state_e;
  state_e state_q;

  logic [6:0] fd_op, dx_op;
  logic [4:0] fd_rs1, fd_rs2, dx_rd;
  logic       fd_uses_rs1, fd_uses_rs2;
  logic       dx_is_load, dx_is_md, load_use;

  assign fd_op  = bus.fd_insn[6:0];
  assign fd_rs1 = bus.fd_insn[19:15];
  assign fd_rs2 = bus.fd_insn[24:20];
  assign dx_op  = bus.dx_insn[6:0];
  assign dx_rd  = bus.dx_insn[11:7];

  assign fd_uses_rs1 = !(fd_op inside {OpLui, OpAuipc, OpJal});
  assign fd_uses_rs2 = fd_op inside {OpR, OpS, OpB};
  assign dx_is_load  = (dx_op == OpLoad);
  assign dx_is_md    = (dx_op == OpR) && (bus.dx_insn[31:25] == 7'b0000001);
  assign load_use    = dx_is_load && (dx_rd != 5'd0) &&
                       ((fd_uses_rs1 && (fd_rs1 == dx_rd)) ||
                        (fd_uses_rs2 && (fd_rs2 == dx_rd)));

  logic md_start, pc_hold, fd_hold, fd_flush, dx_hold, dx_bubble, xm_bubble;

  // The start cycle already freezes DX and bubbles XM so the op is not duplicated
  // into XM while the unit works. Reset forces all controls low immediately.
  always_comb begin
    md_start  = 1'b0;
    pc_hold   = 1'b0;
    fd_hold   = 1'b0;
    fd_flush  = 1'b0;
    dx_hold   = 1'b0;
    dx_bubble = 1'b0;
    xm_bubble = 1'b0;
    if (!reset) begin
      if (state_q == StMdBusy) begin
        pc_hold   = 1'b1;
        fd_hold   = 1'b1;
        dx_hold   = 1'b1;
        xm_bubble = 1'b1;
      end else if (bus.branch_taken) begin
        fd_flush  = 1'b1;
        dx_bubble = 1'b1;
      end else if ((state_q == StIdle) && dx_is_md) begin
        md_start  = 1'b1;
        pc_hold   = 1'b1;
        fd_hold   = 1'b1;
        dx_hold   = 1'b1;
        xm_bubble = 1'b1;
      end else if (load_use) begin
        pc_hold   = 1'b1;
        fd_hold   = 1'b1;
        dx_bubble = 1'b1;
      end
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (md_start) state_q <= StMdBusy;
        StMdBusy: if (bus.md_ready) state_q <= StMdDone;
        StMdDone: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign bus.md_start  = md_start;
  assign bus.pc_hold   = pc_hold;
  assign bus.fd_hold   = fd_hold;
  assign bus.fd_flush  = fd_flush;
  assign bus.dx_hold   = dx_hold;
  assign bus.dx_bubble = dx_bubble;
  assign bus.xm_bubble = xm_bubble;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (pc_hold && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: stimulus pushes expected controls,
// a monitor pops and compares each cycle (and on the asynchronous reset check).
module tb_hazard_ctrl;
  localparam int unsigned CW = 4;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] LW_X5    = 32'h0000_A283;  // lw  x5,0(x1)
  localparam logic [31:0] LW_X0    = 32'h0000_A003;  // lw  x0,0(x1)
  localparam logic [31:0] ADD_X5   = 32'h0022_8333;  // add x6,x5,x2
  localparam logic [31:0] ADD_X0   = 32'h0000_0333;  // add x6,x0,x0
  localparam logic [31:0] ADDI_IMM = 32'h0053_8313;  // addi x6,x7,5
  localparam logic [31:0] SW_X5    = 32'h0051_2023;  // sw  x5,0(x2)
  localparam logic [31:0] LUI_X6   = 32'h0002_8337;  // lui with rs1 field = 5
  localparam logic [31:0] MUL      = 32'h0220_81B3;  // mul x3,x1,x2

  // {md_start, pc_hold, fd_hold, fd_flush, dx_hold, dx_bubble, xm_bubble}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b0110010;
  localparam logic [6:0] C_BR    = 7'b0001010;
  localparam logic [6:0] C_START = 7'b1110101;
  localparam logic [6:0] C_BUSY  = 7'b0110101;

  typedef struct packed {
    logic [6:0]    ctrl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   vec_id = 0;
  int   exp_cnt = 0;
  event chk_ev;

  initial begin
    bus.fd_insn      = 32'h0;
    bus.dx_insn      = 32'h0;
    bus.branch_taken = 1'b0;
    bus.md_ready     = 1'b0;
  end

  function automatic logic [CW-1:0] cnt_expect();
`ifdef HAZARD_PERF_CNT_EN
    return CW'(exp_cnt);
`else
    return '0;
`endif
  endfunction

  task automatic push_exp(input logic [6:0] ctrl);
    exp_t e;
    e.ctrl = ctrl;
    e.cnt  = cnt_expect();
    q.push_back(e);
  endtask

  // Apply one cycle of inputs just after the updating edge and queue the expected outputs.
  task automatic step(input logic rst, input logic [31:0] fd, input logic [31:0] dx,
                      input logic br, input logic rdy, input logic [6:0] ctrl);
    @(negedge clock);
    #1;
    reset            = rst;
    bus.fd_insn      = fd;
    bus.dx_insn      = dx;
    bus.branch_taken = br;
    bus.md_ready     = rdy;
    push_exp(ctrl);
    if (!rst && ctrl[5] && exp_cnt != (1 << CW) - 1) exp_cnt++;
  endtask

  initial begin : monitor
    exp_t e;
    logic [6:0] act;
    forever begin
      @(posedge clock or chk_ev);
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {bus.md_start, bus.pc_hold, bus.fd_hold, bus.fd_flush,
               bus.dx_hold, bus.dx_bubble, bus.xm_bubble};
        n_vec++;
        if (act !== e.ctrl) begin
          n_bad++;
          $display("FAIL v%0d ctrl: got %b want %b", vec_id, act, e.ctrl);
        end
        n_vec++;
        if (bus.stall_cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL v%0d stall_cnt: got %0d want %0d", vec_id, bus.stall_cnt, e.cnt);
        end
        vec_id++;
      end
    end
  end

  initial begin : stim
    step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, C_NONE);        // in reset
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, C_NONE);        // idle after reset
    // load-use: one bubble, then DX=NOP with FD unchanged
    step(1'b0, ADD_X5, LW_X5, 1'b0, 1'b0, C_LU);
    step(1'b0, ADD_X5, NOP, 1'b0, 1'b0, C_NONE);
    // x0 destination and unused rs2 field
    step(1'b0, ADD_X0, LW_X0, 1'b0, 1'b0, C_NONE);
    step(1'b0, ADDI_IMM, LW_X5, 1'b0, 1'b0, C_NONE);
    step(1'b0, SW_X5, LW_X5, 1'b0, 1'b0, C_LU);          // rs2-only dependency
    step(1'b0, LUI_X6, LW_X5, 1'b0, 1'b0, C_NONE);       // LUI has no rs1
    // taken branch wins over load-use, two flushed slots
    step(1'b0, ADD_X5, LW_X5, 1'b1, 1'b0, C_BR);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, C_BR);
    step(1'b0, NOP, NOP, 1'b0, 1'b1, C_NONE);            // stray md_ready in idle
    // mult/div with md_ready three cycles after start; branch ignored while busy
    step(1'b0, ADD_X5, MUL, 1'b0, 1'b0, C_START);
    step(1'b0, ADD_X5, MUL, 1'b0, 1'b0, C_BUSY);
    step(1'b0, ADD_X5, MUL, 1'b1, 1'b0, C_BUSY);
    step(1'b0, ADD_X5, MUL, 1'b0, 1'b1, C_BUSY);
    step(1'b0, ADD_X5, MUL, 1'b0, 1'b0, C_NONE);         // MD_DONE, no restart
    step(1'b0, NOP, ADD_X5, 1'b0, 1'b0, C_NONE);
    // minimum occupancy: ready already high in the first busy cycle
    step(1'b0, NOP, MUL, 1'b0, 1'b0, C_START);
    step(1'b0, NOP, MUL, 1'b0, 1'b1, C_BUSY);
    step(1'b0, NOP, MUL, 1'b0, 1'b1, C_NONE);
    step(1'b0, NOP, NOP, 1'b0, 1'b0, C_NONE);
    // asynchronous reset two cycles into busy
    step(1'b0, NOP, MUL, 1'b0, 1'b0, C_START);
    step(1'b0, NOP, MUL, 1'b0, 1'b0, C_BUSY);
    step(1'b0, NOP, MUL, 1'b0, 1'b0, C_BUSY);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    exp_cnt = 0;
    push_exp(C_NONE);
    ->chk_ev;
    step(1'b1, NOP, MUL, 1'b0, 1'b0, C_NONE);
    step(1'b0, NOP, NOP, 1'b0, 1'b0, C_NONE);
    // long busy run to reach counter saturation
    step(1'b0, NOP, MUL, 1'b0, 1'b0, C_START);
    for (int i = 0; i < 19; i++) step(1'b0, NOP, MUL, 1'b0, 1'b0, C_BUSY);
    step(1'b0, NOP, MUL, 1'b0, 1'b1, C_BUSY);
    step(1'b0, NOP, MUL, 1'b0, 1'b0, C_NONE);
    step(1'b0, NOP, NOP, 1'b0, 1'b0, C_NONE);
    step(1'b0, NOP, NOP, 1'b0, 1'b0, C_NONE);
    @(negedge clock);
    @(posedge clock);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
